// File: rtl/tdm_demux_if.sv
// Stream and per-channel handshake bundle for tdm_demux.
// With TDM_DEMUX_PARITY_EN defined, carries parity_i and par_err_o as well.
`timescale 1ns/1ps

interface tdm_demux_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
);
    logic [DATA_W-1:0]        data_i;
    logic                     valid_i;
    logic                     sof_i;
    logic [NUM_CH-1:0]        ch_ack_i;
    logic [NUM_CH*DATA_W-1:0] ch_data_o;
    logic [NUM_CH-1:0]        ch_valid_o;
    logic [CH_W-1:0]          slot_o;
    logic                     frame_done_o;
    logic                     sync_err_o;
    logic                     overrun_o;
`ifdef TDM_DEMUX_PARITY_EN
    logic                     parity_i;
    logic                     par_err_o;

    modport master (
        output data_i, valid_i, sof_i, ch_ack_i, parity_i,
        input  ch_data_o, ch_valid_o, slot_o, frame_done_o, sync_err_o, overrun_o, par_err_o
    );
    modport slave (
        input  data_i, valid_i, sof_i, ch_ack_i, parity_i,
        output ch_data_o, ch_valid_o, slot_o, frame_done_o, sync_err_o, overrun_o, par_err_o
    );
`else
    modport master (
        output data_i, valid_i, sof_i, ch_ack_i,
        input  ch_data_o, ch_valid_o, slot_o, frame_done_o, sync_err_o, overrun_o
    );
    modport slave (
        input  data_i, valid_i, sof_i, ch_ack_i,
        output ch_data_o, ch_valid_o, slot_o, frame_done_o, sync_err_o, overrun_o
    );
`endif
endinterface

// File: rtl/tdm_demux.sv
// TDM receive demux: routes a framed word stream into NUM_CH valid/ack holding registers.
// Optional even-parity checking on the incoming word when TDM_DEMUX_PARITY_EN is defined.
`timescale 1ns/1ps

module tdm_demux #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    tdm_demux_if.slave   bus
);
    localparam logic [0:0]      StHunt  = 1'b0;
    localparam logic [0:0]      StRun   = 1'b1;
    localparam logic [CH_W-1:0] LastSlot = CH_W'(NUM_CH - 1);

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   slot_q, slot_d;
    logic [DATA_W-1:0] data_q [NUM_CH];
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic              take;
    logic              par_ok;
    logic              fd_q, fd_d;
    logic              se_q, se_d;
    logic              ovr_q, ovr_d;

`ifdef TDM_DEMUX_PARITY_EN
    logic pe_q;
    assign par_ok = ~^{bus.data_i, bus.parity_i};
    assign bus.par_err_o = pe_q;
`else
    assign par_ok = 1'b1;
`endif

    // Slot sequencing: take marks a word that occupies a slot, even if parity later rejects it.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        fd_d    = 1'b0;
        se_d    = 1'b0;
        take    = 1'b0;
        wr_ch   = '0;
        if (bus.valid_i) begin
            if (bus.sof_i) begin
                take    = 1'b1;
                slot_d  = CH_W'(1);
                state_d = StRun;
                se_d    = (state_q == StRun) && (slot_q != '0);
            end else if (state_q == StRun) begin
                take  = 1'b1;
                wr_ch = slot_q;
                if (slot_q == LastSlot) begin
                    slot_d = '0;
                    fd_d   = 1'b1;
                end else begin
                    slot_d = slot_q + CH_W'(1);
                end
            end
        end
    end

    always_comb begin
        wr_en = '0;
        if (take && par_ok) wr_en[wr_ch] = 1'b1;
        ovr_d = ovr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            valid_d[k] = wr_en[k] | (valid_q[k] & ~bus.ch_ack_i[k]);
            // An ack in the same cycle as a write means the old word was consumed.
            if (wr_en[k] && valid_q[k] && !bus.ch_ack_i[k]) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StHunt;
            slot_q  <= '0;
            valid_q <= '0;
            fd_q    <= 1'b0;
            se_q    <= 1'b0;
            ovr_q   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) data_q[k] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            fd_q    <= fd_d;
            se_q    <= se_d;
            ovr_q   <= ovr_d;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en[k]) data_q[k] <= bus.data_i;
            end
`ifdef TDM_DEMUX_PARITY_EN
            pe_q    <= take && !par_ok;
`endif
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign bus.ch_data_o[k*DATA_W +: DATA_W] = data_q[k];
    end

    assign bus.ch_valid_o   = valid_q;
    assign bus.slot_o       = slot_q;
    assign bus.frame_done_o = fd_q;
    assign bus.sync_err_o   = se_q;
    assign bus.overrun_o    = ovr_q;
endmodule
